// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: run controller for the bit-serial sequence detectors.
// Serialises upstream bytes MSB-first and counts overlapping pattern matches.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_start, i_abort    host start strobe (config latch) and run abort
//   i_pattern           pattern, bit 0 = most recently received bit
//   i_pat_len           pattern length in bits, valid 1..PAT_W
//   i_target            match count that ends the run, must be non-zero
//   s_valid/s_data      upstream byte stream
//   s_ready             byte accepted on s_valid && s_ready
//   o_busy              controller not idle
//   o_match             one-cycle pulse per match (registered)
//   o_match_count       matches counted in the current or last run
//   o_done              one-cycle pulse when the target is reached
//   o_err               one-cycle pulse on a start with a bad config
module seq_match_ctrl #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_pat_len,
    input  logic [CNT_W-1:0] i_target,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             o_busy,
    output logic             o_match,
    output logic [CNT_W-1:0] o_match_count,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [7:0]         sh_q, sh_d;
    logic [3:0]         bl_q, bl_d;
    logic [LEN_W-1:0]   seen_q, seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               err_q, err_d;

    logic               proc;
    logic               bit_in;
    logic [PAT_W-1:0]   hist_new;
    logic [PAT_W-1:0]   mask;
    logic [LEN_W:0]     seen_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cfg_ok;
    logic               hit;
    logic               final_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
            hist_q  <= '0;
            sh_q    <= '0;
            bl_q    <= '0;
            seen_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            tgt_q   <= tgt_d;
            hist_q  <= hist_d;
            sh_q    <= sh_d;
            bl_q    <= bl_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    // Datapath terms shared by the FSM below
    always_comb begin
        proc     = (state_q == S_RUN) && (bl_q != 4'd0);
        bit_in   = sh_q[7];
        hist_new = (hist_q << 1) | PAT_W'(bit_in);
        // Shifting by len == PAT_W leaves all ones: full-width compare
        mask     = ~({PAT_W{1'b1}} << len_q);
        seen_inc = {1'b0, seen_q} + (LEN_W+1)'(1);
        cnt_inc  = cnt_q + CNT_W'(1);
        cfg_ok   = (i_pat_len != '0)
                && (i_pat_len <= LEN_W'(PAT_W))
                && (i_target != '0);
        hit      = proc
                && (seen_inc >= {1'b0, len_q})
                && (((hist_new ^ pat_q) & mask) == '0);
        final_hit = hit && (cnt_inc == tgt_q);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        tgt_d   = tgt_q;
        hist_d  = hist_q;
        sh_d    = sh_q;
        bl_d    = bl_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        err_d   = 1'b0;
        s_ready = 1'b0;
        o_done  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (cfg_ok) begin
                        pat_d   = i_pattern;
                        len_d   = i_pat_len;
                        tgt_d   = i_target;
                        hist_d  = '0;
                        seen_d  = '0;
                        cnt_d   = '0;
                        bl_d    = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (i_abort) begin
                    bl_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    // Ready while the last bit drains, so bytes
                    // stream back-to-back; not if this bit ends the run
                    s_ready = (bl_q <= 4'd1) && !final_hit;
                    if (proc) begin
                        hist_d = hist_new;
                        sh_d   = {sh_q[6:0], 1'b0};
                        bl_d   = bl_q - 4'd1;
                        if (seen_q < LEN_W'(PAT_W)) begin
                            seen_d = seen_q + LEN_W'(1);
                        end
                    end
                    if (hit) begin
                        cnt_d   = cnt_inc;
                        match_d = 1'b1;
                    end
                    if (final_hit) begin
                        bl_d    = '0;
                        state_d = S_DONE;
                    end else if (s_valid && s_ready) begin
                        sh_d = s_data;
                        bl_d = 4'd8;
                    end
                end
            end

            S_DONE: begin
                o_done  = !i_abort;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy        = (state_q != S_IDLE);
    assign o_match       = match_q;
    assign o_match_count = cnt_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb_seq_match_ctrl: directed bench for seq_match_ctrl.
// Per-cycle vector table plus hand-written multi-cycle sequences.
module tb_seq_match_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       i_abort;
    logic [7:0] i_pattern;
    logic [4:0] i_pat_len;
    logic [7:0] i_target;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       o_busy;
    logic       o_match;
    logic [7:0] o_match_count;
    logic       o_done;
    logic       o_err;

    int n_chk  = 0;
    int n_fail = 0;

    seq_match_ctrl #(
        .PAT_W(8),
        .LEN_W(5),
        .CNT_W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_pattern    (i_pattern),
        .i_pat_len    (i_pat_len),
        .i_target     (i_target),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .o_busy       (o_busy),
        .o_match      (o_match),
        .o_match_count(o_match_count),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       ab;
        logic [7:0] pat;
        logic [4:0] len;
        logic [7:0] tgt;
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic       busy;
        logic       mt;
        logic [7:0] cnt;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Apply inputs at the falling edge; outputs are then valid for
    // the cycle that ends at the next rising edge.
    task automatic cyc(input logic st, input logic ab,
                       input logic [7:0] pat, input logic [4:0] len,
                       input logic [7:0] tgt, input logic vld,
                       input logic [7:0] dat);
        @(negedge clk);
        i_start   = st;
        i_abort   = ab;
        i_pattern = pat;
        i_pat_len = len;
        i_target  = tgt;
        s_valid   = vld;
        s_data    = dat;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_all(input string nm, input logic rdy,
                           input logic busy, input logic mt,
                           input logic [7:0] cnt, input logic dn,
                           input logic er);
        chk({nm, ".s_ready"}, s_ready, rdy);
        chk({nm, ".busy"}, o_busy, busy);
        chk({nm, ".match"}, o_match, mt);
        chk({nm, ".count"}, o_match_count, cnt);
        chk({nm, ".done"}, o_done, dn);
        chk({nm, ".err"}, o_err, er);
    endtask

    int mcnt;
    int dcnt;
    int acc;
    int first;
    int last_acc;

    initial begin
        rst       = 1'b1;
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_pattern = '0;
        i_pat_len = '0;
        i_target  = '0;
        s_valid   = 1'b0;
        s_data    = '0;

        // pattern 01 len 2 target 3 on 0x55, then bad configs
        tbl[0]  = '{1'b1,1'b0,8'h01,5'd2,8'd3,1'b0,8'h00,
                    1'b0,1'b0,1'b0,8'd0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'h55,
                    1'b1,1'b1,1'b0,8'd0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b1,1'b0,8'd0,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b1,1'b0,8'd0,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b1,1'b1,8'd1,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b1,1'b0,8'd1,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b1,1'b1,8'd2,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b1,1'b0,8'd2,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b1,1'b1,8'd3,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b0,1'b0,8'd3,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,8'h01,5'd0,8'd3,1'b1,8'hAA,
                    1'b0,1'b0,1'b0,8'd3,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b0,8'h01,5'd9,8'd3,1'b1,8'hAA,
                    1'b0,1'b0,1'b0,8'd3,1'b0,1'b1};
        tbl[12] = '{1'b1,1'b0,8'h01,5'd2,8'd0,1'b1,8'hAA,
                    1'b0,1'b0,1'b0,8'd3,1'b0,1'b1};
        tbl[13] = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b0,1'b0,8'd3,1'b0,1'b1};
        tbl[14] = '{1'b0,1'b0,8'h01,5'd2,8'd3,1'b1,8'hAA,
                    1'b0,1'b0,1'b0,8'd3,1'b0,1'b0};

        // Reset state
        do_reset();
        cyc(1'b0, 1'b0, 8'h00, 5'd0, 8'd0, 1'b1, 8'hFF);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].st, tbl[i].ab, tbl[i].pat, tbl[i].len,
                tbl[i].tgt, tbl[i].vld, tbl[i].dat);
            chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].busy,
                    tbl[i].mt, tbl[i].cnt, tbl[i].dn, tbl[i].er);
        end

        // Pattern 11 len 2 target 5 on 0xF0: three overlapping matches
        do_reset();
        cyc(1'b1, 1'b0, 8'h03, 5'd2, 8'd5, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h03, 5'd2, 8'd5, 1'b1, 8'hF0);
        chk("ovl.accept", s_ready, 1'b1);
        mcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 8'h03, 5'd2, 8'd5, 1'b0, 8'h00);
            mcnt += int'(o_match);
            dcnt += int'(o_done);
        end
        chk("ovl.pulses", mcnt, 3);
        chk("ovl.done", dcnt, 0);
        chk("ovl.count", o_match_count, 8'd3);
        chk("ovl.busy", o_busy, 1'b1);
        chk("ovl.ready", s_ready, 1'b1);

        // Pattern 1001 len 4 target 1 across bytes 0x01, 0x20
        do_reset();
        cyc(1'b1, 1'b0, 8'h09, 5'd4, 8'd1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h09, 5'd4, 8'd1, 1'b1, 8'h01);
        chk("xb.accept0", s_ready, 1'b1);
        mcnt  = 0;
        dcnt  = 0;
        acc   = 1;
        first = -1;
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b0, 8'h09, 5'd4, 8'd1, 1'b1, 8'h20);
            if (s_ready) acc++;
            if (o_match) begin
                mcnt++;
                if (first < 0) first = i;
            end
            if (o_done) begin
                dcnt++;
                chk("xb.done_cycle", i, 12);
            end
        end
        chk("xb.pulses", mcnt, 1);
        chk("xb.match_cycle", first, 12);
        chk("xb.dones", dcnt, 1);
        chk("xb.accepts", acc, 2);
        chk("xb.count", o_match_count, 8'd1);
        chk("xb.busy", o_busy, 1'b0);

        // Zero bytes streamed with s_valid held: accepts 8 apart
        do_reset();
        cyc(1'b1, 1'b0, 8'h01, 5'd1, 8'd1, 1'b0, 8'h00);
        acc      = 0;
        mcnt     = 0;
        last_acc = -8;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b0, 8'h01, 5'd1, 8'd1, 1'b1, 8'h00);
            mcnt += int'(o_match);
            if (s_ready) begin
                chk($sformatf("zero.gap%0d", acc), i - last_acc, 8);
                last_acc = i;
                acc++;
            end
        end
        chk("zero.accepts", acc, 4);
        chk("zero.pulses", mcnt, 0);

        // Abort before bit 4 of 0xFF, then restart on 0xF0
        do_reset();
        cyc(1'b1, 1'b0, 8'h0F, 5'd4, 8'd5, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h0F, 5'd4, 8'd5, 1'b1, 8'hFF);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 8'h0F, 5'd4, 8'd5, 1'b0, 8'h00);
        end
        cyc(1'b0, 1'b1, 8'h0F, 5'd4, 8'd5, 1'b1, 8'h00);
        chk("abort.ready", s_ready, 1'b0);
        dcnt = 0;
        mcnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 8'h0F, 5'd4, 8'd5, 1'b0, 8'h00);
            dcnt += int'(o_done);
            mcnt += int'(o_match);
        end
        chk("abort.done", dcnt, 0);
        chk("abort.match", mcnt, 0);
        chk("abort.busy", o_busy, 1'b0);
        chk("abort.count", o_match_count, 8'd0);
        cyc(1'b1, 1'b0, 8'h0F, 5'd4, 8'd5, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h0F, 5'd4, 8'd5, 1'b1, 8'hF0);
        chk("restart.accept", s_ready, 1'b1);
        mcnt  = 0;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 1'b0, 8'h0F, 5'd4, 8'd5, 1'b0, 8'h00);
            if (o_match) begin
                mcnt++;
                if (first < 0) first = i;
            end
        end
        chk("restart.first", first, 5);
        chk("restart.pulses", mcnt, 1);
        chk("restart.count", o_match_count, 8'd1);

        // Reset mid-run, with a match pulse in flight
        cyc(1'b0, 1'b0, 8'h0F, 5'd4, 8'd5, 1'b1, 8'hFF);
        chk("mid.accept", s_ready, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b0, 8'h0F, 5'd4, 8'd5, 1'b0, 8'h00);
        end
        chk("mid.match", o_match, 1'b1);
        chk("mid.count", o_match_count, 8'd2);
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("midrst", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
